// File: rtl/ram_responder.sv
// Bus-side data RAM responder: programmable wait states, tri-state read drive,
// write commit on the sampled address, and a one-cycle error pulse on out-of-range access.
module ram_responder #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 16,
    parameter int DEPTH_LOG2  = 8,
    parameter int WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cs,
    input  logic              read,
    input  logic [ADDR_W-1:0] address,
    inout  wire  [DATA_W-1:0] data,
    output logic              ready,
    output logic              err
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_XFER,
        S_RDRIVE,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                ready_q, ready_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic                mem_we;
    logic                in_range;
    logic [DEPTH_LOG2-1:0] idx;
    logic                drive_en;

    assign idx      = address[DEPTH_LOG2-1:0];
    assign in_range = (address[ADDR_W-1:DEPTH_LOG2] == '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = 1'b0;
        mem_we  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cs) begin
                    if (WAIT_STATES > 0) begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_INIT;
                    end else begin
                        state_d = S_XFER;
                    end
                end
            end
            S_WAIT: begin
                if (!cs)              state_d = S_IDLE;
                else if (cnt_q == 4'd0) state_d = S_XFER;
                else                  cnt_d = cnt_q - 4'd1;
            end
            S_XFER: begin
                if (!cs) begin
                    state_d = S_IDLE;
                end else begin
                    err_d = !in_range;
                    if (read) begin
                        rdata_d = in_range ? mem_q[idx] : '0;
                        state_d = S_RDRIVE;
                    end else begin
                        mem_we  = in_range;
                        state_d = S_DONE;
                    end
                end
            end
            S_RDRIVE, S_DONE: begin
                if (!cs) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        ready_d = (state_d != S_WAIT);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            ready_q <= 1'b1;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    // Storage survives reset; a reset edge only suppresses the pending commit.
    always_ff @(posedge clk) begin
        if (rst_n && mem_we) mem_q[idx] <= data;
    end

    // Released the moment read drops so the master can never collide with us.
    assign drive_en = (state_q == S_RDRIVE) && cs && read;
    assign data     = drive_en ? rdata_q : {DATA_W{1'bz}};

    assign ready = ready_q;
    assign err   = err_q;

endmodule
